// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, load-store) onto one memory port.
//
// A three-state FSM (StIdle -> StIssue -> StWait) keeps at most one transaction outstanding.
// The winning request's payload is latched in StIdle, presented on mem_* in StIssue until
// mem_ready, and the response is forwarded to the owner in StWait.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req, if_addr                   fetch request and address (read only)
//   if_gnt, if_rvalid, if_rdata       fetch accept pulse and response
//   ls_req, ls_we, ls_addr,
//   ls_wdata, ls_be                   load-store request and payload
//   ls_gnt, ls_rvalid, ls_rdata       load-store accept pulse and response (load data or write ack)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                 memory command
//   mem_ready                         memory accepts when mem_req && mem_ready
//   mem_rvalid, mem_rdata             memory response (reads and writes)
//
// Configuration
//   MEM_ARB_ROUND_ROBIN_EN  undefined: fixed priority, ls over if.
//                           defined:   on a tie the requester not granted most recently wins.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // Instruction fetch
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // Load-store
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  // Memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e              r_state;
  state_e              w_state_next;

  logic                r_owner_ls;  // 1: load-store owns the transaction, 0: fetch
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;

  logic                w_any_req;
  logic                w_pick_ls;
  logic                w_accept;
  logic                w_resp;

  assign w_any_req = if_req | ls_req;
  assign w_accept  = (r_state == StIssue) & mem_ready;
  // mem_rvalid outside StWait is not ours and is dropped
  assign w_resp    = (r_state == StWait) & mem_rvalid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_ls;  // most recent grant went to load-store

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_ls <= 1'b0;
    end else if (w_accept) begin
      r_last_ls <= r_owner_ls;
    end
  end

  // ls wins alone, or on a tie when fetch was the most recent winner
  assign w_pick_ls = ls_req & (~if_req | ~r_last_ls);
`else
  assign w_pick_ls = ls_req;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req)  w_state_next = StIssue;
      StIssue: if (mem_ready)  w_state_next = StWait;
      StWait:  if (mem_rvalid) w_state_next = StIdle;
      default:                 w_state_next = StIdle;
    endcase
  end

  // Winner payload is captured only in StIdle, so requester changes afterwards are invisible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner_ls <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else if ((r_state == StIdle) && w_any_req) begin
      r_owner_ls <= w_pick_ls;
      if (w_pick_ls) begin
        r_addr  <= ls_addr;
        r_we    <= ls_we;
        r_wdata <= ls_wdata;
        r_be    <= ls_be;
      end else begin
        // Fetch is always a full-word read
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_be    <= '1;
      end
    end
  end

  // Outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;

    if (r_state == StIssue) begin
      mem_req   = 1'b1;
      mem_we    = r_we;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      mem_be    = r_be;
    end

    if (w_accept) begin
      ls_gnt = r_owner_ls;
      if_gnt = ~r_owner_ls;
    end

    if (w_resp) begin
      if (r_owner_ls) begin
        ls_rvalid = 1'b1;
        ls_rdata  = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end
  end

endmodule
